spi_erase_ctrl: RTL and testbench

Sequences a full SPI NOR chip erase. It issues Write Enable (0x06), then Chip Erase (0xC7), then polls Read Status Register (0x05) until the WIP bit clears. The SPI clock comes from an internal clock-enable divider, SPI mode 0, MSB first. The block sits between the top-level key/start logic and the flash pins, and owns the SPI bus exclusively while busy.

---
 rtl/spi_flash_pkg.sv | 28 ++
 rtl/spi_erase_ctrl_if.sv | 28 ++
 rtl/spi_shift_engine.sv | 89 ++++++++
 rtl/spi_erase_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_spi_erase_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_flash_pkg.sv
// Shared constants for the SPI NOR chip-erase sequencer.
//   OP_*      : flash opcodes issued by the sequencer
//   WIP_BIT   : bit of the status register that reads 1 while the erase runs
//   LEN_*     : frame lengths in SCLK cycles
//   state_t   : sequencer state encoding
package spi_flash_pkg;

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_CE   = 8'hC7;
    localparam logic [7:0] OP_RDSR = 8'h05;

    localparam int WIP_BIT = 0;

    localparam logic [4:0] LEN_CMD  = 5'd8;
    localparam logic [4:0] LEN_POLL = 5'd16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WREN  = 3'd1,
        S_GAP1  = 3'd2,
        S_ERASE = 3'd3,
        S_GAP2  = 3'd4,
        S_POLL  = 3'd5,
        S_PGAP  = 3'd6,
        S_FIN   = 3'd7
    } state_t;

endpackage

// File: rtl/spi_erase_ctrl_if.sv
// Bundle of the request handshake and the flash pins of spi_erase_ctrl.
//   start    : single-cycle erase request
//   busy     : sequence in progress
//   done     : one-cycle completion pulse
//   err      : sticky timeout flag
//   spi_cs_n, spi_sclk, spi_mosi : flash outputs (mode 0)
//   spi_miso : flash data in
// master = the erase controller, slave = start logic plus flash.
interface spi_erase_ctrl_if;
    logic start;
    logic busy;
    logic done;
    logic err;
    logic spi_cs_n;
    logic spi_sclk;
    logic spi_mosi;
    logic spi_miso;

    modport master (
        input  start, spi_miso,
        output busy, done, err, spi_cs_n, spi_sclk, spi_mosi
    );

    modport slave (
        output start, spi_miso,
        input  busy, done, err, spi_cs_n, spi_sclk, spi_mosi
    );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI mode-0 frame engine, MSB first. One frame per load pulse:
// cs_n falls with the first MOSI bit already set up, bit_cnt SCLK cycles are
// generated from a CLK_DIV clock-enable divider, and cs_n rises one
// half-period after the last falling edge, with a frame_done pulse.
// Ports:
//   clk, rst   : system clock, async active-high reset
//   load       : start a frame (ignored while a frame is running)
//   tx_byte    : first byte shifted out; remaining bits are sent as 0
//   bit_cnt    : number of SCLK cycles in the frame (8 or 16)
//   rx_byte    : last 8 bits sampled on MISO, MSB first
//   frame_done : one-cycle pulse on the edge cs_n rises
//   cs_n, sclk, mosi, miso : flash pins
module spi_shift_engine #(
    parameter int CLK_DIV = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] tx_byte,
    input  logic [4:0] bit_cnt,
    output logic [7:0] rx_byte,
    output logic       frame_done,
    output logic       cs_n,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    localparam logic [3:0] DIV_TC = 4'(CLK_DIV - 1);

    logic        active;
    logic [3:0]  div_cnt;
    logic [5:0]  half_cnt;
    logic [5:0]  half_last;
    logic [15:0] tx_sr;
    logic        tick;

    assign tick = active && (div_cnt == DIV_TC);

    // Half-period ticks 0..2N-1 toggle sclk; tick 2N closes the frame, which
    // gives the trailing half-period of cs_n hold after the last falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active     <= 1'b0;
            div_cnt    <= '0;
            half_cnt   <= '0;
            half_last  <= '0;
            tx_sr      <= '0;
            rx_byte    <= '0;
            frame_done <= 1'b0;
            cs_n       <= 1'b1;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (load && !active) begin
                active    <= 1'b1;
                cs_n      <= 1'b0;
                sclk      <= 1'b0;
                div_cnt   <= '0;
                half_cnt  <= '0;
                half_last <= {bit_cnt, 1'b0};
                tx_sr     <= {tx_byte, 8'h00};
                mosi      <= tx_byte[7];
            end else if (active) begin
                if (tick) begin
                    div_cnt  <= '0;
                    half_cnt <= half_cnt + 6'd1;
                    if (half_cnt == half_last) begin
                        active     <= 1'b0;
                        cs_n       <= 1'b1;
                        mosi       <= 1'b0;
                        frame_done <= 1'b1;
                    end else if (!sclk) begin
                        sclk    <= 1'b1;
                        rx_byte <= {rx_byte[6:0], miso};
                    end else begin
                        sclk  <= 1'b0;
                        tx_sr <= {tx_sr[14:0], 1'b0};
                        mosi  <= tx_sr[14];
                    end
                end else begin
                    div_cnt <= div_cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_erase_ctrl.sv
// SPI NOR chip-erase sequencer: WREN, CE, then RDSR polling until WIP clears.
// Owns the flash bus while busy; frames are produced by spi_shift_engine.
// Build option: ERASE_TIMEOUT_EN ends polling after POLL_MAX status frames
// with WIP still set, reporting err.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : spi_erase_ctrl_if.master (start/busy/done/err + flash pins)
//
// state | meaning
// IDLE  | waiting for start
// WREN  | write-enable frame on the bus
// GAP1  | cs_n deselect time after WREN
// ERASE | chip-erase frame on the bus
// GAP2  | cs_n deselect time after CE
// POLL  | read-status frame on the bus
// PGAP  | cs_n deselect time, then decide on the captured WIP bit
// FIN   | done pulse, back to IDLE
module spi_erase_ctrl
    import spi_flash_pkg::*;
#(
    parameter int          CLK_DIV  = 5,
    parameter int          CS_GAP   = 10,
    parameter logic [23:0] POLL_MAX = 24'd16_000_000
) (
    input logic               clk,
    input logic               rst,
    spi_erase_ctrl_if.master  bus
);

    localparam logic [7:0] GAP_TC = 8'(CS_GAP - 1);

    state_t     state, state_nxt;
    logic [7:0] gap_cnt, gap_nxt;
    logic       busy_q, busy_nxt;
    logic       done_q, done_nxt;
    logic       err_q, err_nxt;

    logic       load;
    logic [7:0] tx_byte;
    logic [4:0] bit_cnt;
    logic [7:0] status;
    logic       frame_done;
    logic       cs_n, sclk, mosi;

`ifdef ERASE_TIMEOUT_EN
    logic [23:0] poll_cnt, poll_cnt_nxt;
`else
    logic unused_poll_max;
    assign unused_poll_max = ^POLL_MAX;
`endif

    // Only the WIP bit of the captured status decides the next step.
    logic unused_status;
    assign unused_status = ^status[7:1];

    spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_engine (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .tx_byte    (tx_byte),
        .bit_cnt    (bit_cnt),
        .rx_byte    (status),
        .frame_done (frame_done),
        .cs_n       (cs_n),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (bus.spi_miso)
    );

    assign bus.spi_cs_n = cs_n;
    assign bus.spi_sclk = sclk;
    assign bus.spi_mosi = mosi;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            gap_cnt  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef ERASE_TIMEOUT_EN
            poll_cnt <= '0;
`endif
        end else begin
            state    <= state_nxt;
            gap_cnt  <= gap_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
            err_q    <= err_nxt;
`ifdef ERASE_TIMEOUT_EN
            poll_cnt <= poll_cnt_nxt;
`endif
        end
    end

    // Frames are launched on the transition into their state, so cs_n falls
    // on the same edge the state register moves.
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        err_nxt   = err_q;
        load      = 1'b0;
        tx_byte   = OP_WREN;
        bit_cnt   = LEN_CMD;
`ifdef ERASE_TIMEOUT_EN
        poll_cnt_nxt = poll_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_WREN;
                    err_nxt   = 1'b0;
                    load      = 1'b1;
                    tx_byte   = OP_WREN;
`ifdef ERASE_TIMEOUT_EN
                    poll_cnt_nxt = '0;
`endif
                end
            end
            S_WREN: begin
                if (frame_done) begin
                    state_nxt = S_GAP1;
                    gap_nxt   = GAP_TC;
                end
            end
            S_GAP1: begin
                if (gap_cnt != '0) begin
                    gap_nxt = gap_cnt - 8'd1;
                end else begin
                    state_nxt = S_ERASE;
                    load      = 1'b1;
                    tx_byte   = OP_CE;
                end
            end
            S_ERASE: begin
                if (frame_done) begin
                    state_nxt = S_GAP2;
                    gap_nxt   = GAP_TC;
                end
            end
            S_GAP2: begin
                if (gap_cnt != '0) begin
                    gap_nxt = gap_cnt - 8'd1;
                end else begin
                    state_nxt = S_POLL;
                    load      = 1'b1;
                    tx_byte   = OP_RDSR;
                    bit_cnt   = LEN_POLL;
                end
            end
            S_POLL: begin
                if (frame_done) begin
                    state_nxt = S_PGAP;
                    gap_nxt   = GAP_TC;
`ifdef ERASE_TIMEOUT_EN
                    poll_cnt_nxt = poll_cnt + 24'd1;
`endif
                end
            end
            S_PGAP: begin
                if (gap_cnt != '0) begin
                    gap_nxt = gap_cnt - 8'd1;
                end else if (!status[WIP_BIT]) begin
                    state_nxt = S_FIN;
`ifdef ERASE_TIMEOUT_EN
                end else if (poll_cnt >= POLL_MAX) begin
                    state_nxt = S_FIN;
                    err_nxt   = 1'b1;
`endif
                end else begin
                    state_nxt = S_POLL;
                    load      = 1'b1;
                    tx_byte   = OP_RDSR;
                    bit_cnt   = LEN_POLL;
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Registered from next-state so busy falls on the edge done rises.
        busy_nxt = (state_nxt != S_IDLE) && (state_nxt != S_FIN);
        done_nxt = (state_nxt == S_FIN);
    end

endmodule

// File: tb/tb_spi_erase_ctrl.sv
module tb_spi_erase_ctrl;

    localparam int          CLK_DIV  = 5;
    localparam int          CS_GAP   = 10;
    localparam logic [23:0] POLL_MAX = 24'd4;
    localparam int          LIMIT    = 20000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    spi_erase_ctrl_if bus();

    spi_erase_ctrl #(
        .CLK_DIV  (CLK_DIV),
        .CS_GAP   (CS_GAP),
        .POLL_MAX (POLL_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Flash model and bus monitor, sampled on the falling clk edge.
    logic [15:0] frames_q[$];
    int          lens_q[$];
    logic [15:0] fr_bits;
    logic [7:0]  cur_status;
    int fr_len, hi_len, lo_len, gap_len, bit_idx;
    int timing_err, mosi_err, gap_err, idle_sclk_err, done_cnt;
    int poll_idx, poll_base, busy_polls;
    bit seen_frame, first_low;
    bit prev_cs   = 1'b1;
    bit prev_sclk = 1'b0;
    bit prev_mosi = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_cs      = 1'b1;
            prev_sclk    = 1'b0;
            prev_mosi    = 1'b0;
            fr_len       = 0;
            seen_frame   = 1'b0;
            bus.spi_miso = 1'b0;
        end else begin
            if (bus.spi_cs_n && bus.spi_sclk) idle_sclk_err++;
            if (bus.done) done_cnt++;
            if (prev_cs && !bus.spi_cs_n) begin
                if (seen_frame && gap_len < CS_GAP) gap_err++;
                fr_bits   = '0;
                fr_len    = 0;
                hi_len    = 0;
                lo_len    = 0;
                first_low = 1'b1;
            end else if (!prev_cs && bus.spi_cs_n) begin
                if (lo_len < CLK_DIV) timing_err++;
                frames_q.push_back(fr_bits);
                lens_q.push_back(fr_len);
                gap_len    = 0;
                seen_frame = 1'b1;
            end
            if (bus.spi_cs_n) begin
                gap_len++;
            end else begin
                if (!prev_sclk && bus.spi_sclk) begin
                    if (bus.spi_mosi !== prev_mosi) mosi_err++;
                    fr_bits = {fr_bits[14:0], bus.spi_mosi};
                    fr_len++;
                    if (first_low ? (lo_len < CLK_DIV) : (lo_len != CLK_DIV)) timing_err++;
                    first_low = 1'b0;
                    hi_len    = 0;
                end else if (prev_sclk && !bus.spi_sclk) begin
                    if (hi_len != CLK_DIV) timing_err++;
                    lo_len = 0;
                    if (fr_len == 8 && fr_bits[7:0] == 8'h05) begin
                        if ((poll_idx - poll_base) < busy_polls)
                            cur_status = 8'($urandom) | 8'h01;
                        else
                            cur_status = 8'($urandom) & 8'hFE;
                        poll_idx++;
                    end
                    if (fr_len >= 8 && fr_len < 16) begin
                        bit_idx      = 15 - fr_len;
                        bus.spi_miso = cur_status[bit_idx];
                    end
                end
                if (bus.spi_sclk) hi_len++;
                else              lo_len++;
            end
            prev_cs   = bus.spi_cs_n;
            prev_sclk = bus.spi_sclk;
            prev_mosi = bus.spi_mosi;
        end
    end

    // One complete erase; the flash reports WIP=1 for the first n_busy polls.
    task automatic run_erase(input int n_busy, input bit dbl_start);
        int cyc, busy_low, exp_polls, fbase, tbase, mbase, gbase, ibase, dbase;
        bit exp_err;
        logic [31:0] exp_frame;
        exp_polls = n_busy + 1;
        exp_err   = 1'b0;
`ifdef ERASE_TIMEOUT_EN
        if (exp_polls > int'(POLL_MAX)) begin
            exp_polls = int'(POLL_MAX);
            exp_err   = 1'b1;
        end
`endif
        busy_polls = n_busy;
        poll_base  = poll_idx;
        fbase = frames_q.size();
        tbase = timing_err;
        mbase = mosi_err;
        gbase = gap_err;
        ibase = idle_sclk_err;
        dbase = done_cnt;

        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        check_eq("accept_busy", bus.busy, 1'b1);
        check_eq("accept_err_clr", bus.err, 1'b0);

        cyc = 0;
        busy_low = 0;
        while (bus.done !== 1'b1 && cyc < LIMIT) begin
            @(posedge clk); #1;
            cyc++;
            bus.start = dbl_start && (cyc == 40 || cyc == 300);
            if (bus.done !== 1'b1 && bus.busy !== 1'b1) busy_low++;
        end
        bus.start = 1'b0;
        check_eq("done_seen", cyc < LIMIT, 1'b1);
        check_eq("busy_in_seq", busy_low, 0);
        check_eq("busy_at_done", bus.busy, 1'b0);
        check_eq("err_at_done", bus.err, exp_err);
        @(posedge clk); #1;
        check_eq("done_width", bus.done, 1'b0);
        repeat (300) @(posedge clk);
        #1;
        check_eq("done_count", done_cnt - dbase, 1);
        check_eq("err_sticky", bus.err, exp_err);
        check_eq("frame_count", frames_q.size() - fbase, 2 + exp_polls);
        for (int i = 0; i < 2 + exp_polls && fbase + i < frames_q.size(); i++) begin
            if (i == 0)      exp_frame = {8'd0, 8'd8,  16'h0006};
            else if (i == 1) exp_frame = {8'd0, 8'd8,  16'h00C7};
            else             exp_frame = {8'd0, 8'd16, 16'h0500};
            check_eq("frame", {8'd0, 8'(lens_q[fbase + i]), frames_q[fbase + i]}, exp_frame);
        end
        check_eq("sclk_timing", timing_err - tbase, 0);
        check_eq("mosi_stable", mosi_err - mbase, 0);
        check_eq("cs_gap", gap_err - gbase, 0);
        check_eq("sclk_idle_low", idle_sclk_err - ibase, 0);
    endtask

    task automatic reset_mid_erase();
        int cyc, fbase;
        fbase = frames_q.size();
        busy_polls = 0;
        poll_base  = poll_idx;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        cyc = 0;
        while (!(frames_q.size() == fbase + 1 && bus.spi_cs_n == 1'b0 && fr_len >= 3) && cyc < LIMIT) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("erase_frame_reached", cyc < LIMIT, 1'b1);
        #3 rst = 1'b1;
        #1;
        check_eq("midrst_cs_n", bus.spi_cs_n, 1'b1);
        check_eq("midrst_sclk", bus.spi_sclk, 1'b0);
        check_eq("midrst_mosi", bus.spi_mosi, 1'b0);
        check_eq("midrst_busy", bus.busy, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        check_eq("no_resume_busy", bus.busy, 1'b0);
        check_eq("no_resume_cs_n", bus.spi_cs_n, 1'b1);
    endtask

    initial begin
        bus.start = 1'b0;
        #1 rst = 1'b1;
        #4;
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_done", bus.done, 1'b0);
        check_eq("rst_err", bus.err, 1'b0);
        check_eq("rst_cs_n", bus.spi_cs_n, 1'b1);
        check_eq("rst_sclk", bus.spi_sclk, 1'b0);
        check_eq("rst_mosi", bus.spi_mosi, 1'b0);

        // start coincident with reset must be dropped
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_wins_busy", bus.busy, 1'b0);
        bus.start = 1'b0;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_eq("rst_wins_cs_n", bus.spi_cs_n, 1'b1);
        check_eq("rst_wins_idle", bus.busy, 1'b0);

        run_erase(0, 1'b0);
        run_erase(3, 1'b0);
        run_erase(2, 1'b1);
        reset_mid_erase();
        run_erase(0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            run_erase(int'($urandom_range(0, 5)), 1'b0);
        end
`ifdef ERASE_TIMEOUT_EN
        run_erase(6, 1'b0);
        run_erase(0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
